// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver. The rx line is oversampled at 16x the selected
// baud rate. Each frame is 1 start bit, 8 data bits (LSB first), an optional
// parity bit and 1 stop bit. Good bytes are pushed into a DEPTH-entry
// synchronous FIFO that the host drains with rd_en.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active low
//   rx           serial input, idles high, asynchronous to clk
//   baud_rate    00=2400 01=4800 10=9600 11=19200 (latched at start detection)
//   parity_type  00=none 01=odd 10=even 11=none (latched at start detection)
//   rd_en        pop one byte; ignored while the FIFO is empty
//   data_out     registered FIFO read data
//   fifo_empty   FIFO holds no bytes
//   fifo_full    FIFO holds DEPTH bytes
//   active       receiver is inside a frame
//   parity_err   one-cycle pulse on parity mismatch
//   frame_err    one-cycle pulse when the stop bit samples 0
//   overrun      one-cycle pulse when a good byte is dropped on a full FIFO
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       active,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int AW        = $clog2(DEPTH);
    localparam int PW        = AW + 1;
    localparam int DIV_2400  = CLK_HZ / (16 * 2400);
    localparam int DIV_4800  = CLK_HZ / (16 * 4800);
    localparam int DIV_9600  = CLK_HZ / (16 * 9600);
    localparam int DIV_19200 = CLK_HZ / (16 * 19200);
    localparam int DW        = $clog2(DIV_2400 + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // True when the received data/parity combination violates the check.
    // odd = 1 demands an odd number of ones across data and parity bit.
    function automatic logic parity_bad(input logic [7:0] data,
                                        input logic       par_bit,
                                        input logic       odd);
        return (((^data) ^ par_bit) != odd);
    endfunction

    // ---------------------------------------------------------------- signals
    logic          rx_meta_r;
    logic          rxs_r;

    state_t        state_r;
    state_t        state_n;

    logic [DW-1:0] div_cnt_r;
    logic [DW-1:0] div_last_s;
    logic          tick_s;
    logic [3:0]    os_cnt_r;
    logic          bit_done_s;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          par_bit_r;
    logic [1:0]    baud_sel_r;
    logic [1:0]    par_sel_r;
    logic          par_en_s;
    logic          start_s;
    logic          stop_sample_s;
    logic          par_bad_s;
    logic          good_s;
    logic          wr_en_s;
    logic          rd_do_s;

    logic          active_r;
    logic          parity_err_r;
    logic          frame_err_r;
    logic          overrun_r;

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_n;
    logic [PW-1:0] rd_ptr_n;
    logic          fifo_empty_r;
    logic          fifo_full_r;
    logic [7:0]    data_out_r;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // Oversample divisor terminal count for the baud rate latched for this frame.
    always_comb begin
        div_last_s = DW'(DIV_19200 - 1);
        case (baud_sel_r)
            2'b00:   div_last_s = DW'(DIV_2400 - 1);
            2'b01:   div_last_s = DW'(DIV_4800 - 1);
            2'b10:   div_last_s = DW'(DIV_9600 - 1);
            2'b11:   div_last_s = DW'(DIV_19200 - 1);
            default: div_last_s = DW'(DIV_19200 - 1);
        endcase
    end

    // Frame timing decodes. The start bit is checked after 8 ticks (mid-bit);
    // every later bit is sampled 16 ticks after the previous sample.
    always_comb begin
        tick_s   = 1'b0;
        par_en_s = (par_sel_r == 2'b01) || (par_sel_r == 2'b10);
        start_s  = (state_r == ST_IDLE) && !rxs_r;
        if (state_r != ST_IDLE) begin
            tick_s = (div_cnt_r == div_last_s);
        end else begin
            tick_s = 1'b0;
        end
        if (state_r == ST_START) begin
            bit_done_s = tick_s && (os_cnt_r == 4'd7);
        end else begin
            bit_done_s = tick_s && (os_cnt_r == 4'd15);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic and stop-sample strobe.
    always_comb begin
        state_n       = state_r;
        stop_sample_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_r) begin
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rxs_r) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s && (bit_idx_r == 3'd7)) begin
                    if (par_en_s) begin
                        state_n = ST_PARITY;
                    end else begin
                        state_n = ST_STOP;
                    end
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_n = ST_STOP;
                end else begin
                    state_n = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is caught.
                if (bit_done_s) begin
                    state_n       = ST_IDLE;
                    stop_sample_s = 1'b1;
                end else begin
                    state_n = ST_STOP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Tick generator, oversample counter, shift register and frame settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r  <= {DW{1'b0}};
            os_cnt_r   <= 4'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            par_bit_r  <= 1'b0;
            baud_sel_r <= 2'b00;
            par_sel_r  <= 2'b00;
        end else if (start_s) begin
            div_cnt_r  <= {DW{1'b0}};
            os_cnt_r   <= 4'd0;
            bit_idx_r  <= 3'd0;
            baud_sel_r <= baud_rate;
            par_sel_r  <= parity_type;
        end else if (state_r != ST_IDLE) begin
            if (tick_s) begin
                div_cnt_r <= {DW{1'b0}};
                if (bit_done_s) begin
                    os_cnt_r <= 4'd0;
                end else begin
                    os_cnt_r <= os_cnt_r + 4'd1;
                end
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
            if (bit_done_s && (state_r == ST_DATA)) begin
                shift_r   <= {rxs_r, shift_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if (bit_done_s && (state_r == ST_PARITY)) begin
                par_bit_r <= rxs_r;
            end
        end else begin
            div_cnt_r <= {DW{1'b0}};
            os_cnt_r  <= 4'd0;
        end
    end

    // Frame outcome at the stop sample. A bad stop bit masks the parity result.
    always_comb begin
        if (par_en_s) begin
            par_bad_s = parity_bad(shift_r, par_bit_r, par_sel_r == 2'b01);
        end else begin
            par_bad_s = 1'b0;
        end
        good_s  = stop_sample_s && rxs_r && !par_bad_s;
        wr_en_s = good_s && !fifo_full_r;
        rd_do_s = rd_en && !fifo_empty_r;
    end

    // Registered status outputs and one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r     <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            active_r     <= (state_n != ST_IDLE);
            frame_err_r  <= stop_sample_s && !rxs_r;
            parity_err_r <= stop_sample_s && rxs_r && par_bad_s;
            overrun_r    <= good_s && fifo_full_r;
        end
    end

    // FIFO pointer next values; the extra MSB separates full from empty.
    always_comb begin
        if (wr_en_s) begin
            wr_ptr_n = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_n = wr_ptr_r;
        end
        if (rd_do_s) begin
            rd_ptr_n = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_n = rd_ptr_r;
        end
    end

    // FIFO storage; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        end
    end

    // FIFO pointers, registered flags and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fifo_empty_r <= 1'b1;
            fifo_full_r  <= 1'b0;
            data_out_r   <= 8'h00;
        end else begin
            wr_ptr_r     <= wr_ptr_n;
            rd_ptr_r     <= rd_ptr_n;
            fifo_empty_r <= (wr_ptr_n == rd_ptr_n);
            fifo_full_r  <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                            (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
            if (rd_do_s) begin
                data_out_r <= mem_r[rd_ptr_r[AW-1:0]];
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign data_out   = data_out_r;
    assign fifo_empty = fifo_empty_r;
    assign fifo_full  = fifo_full_r;
    assign active     = active_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;

endmodule
